counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 134 +++++++++++++
 tb/tb_counter_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Purpose : start/stop period counter with optional auto-reload and terminal-count pulse.
// Latency : count is 0 the edge after start and reaches P after P more edges; tc and done follow one edge later.
// Backpres: none; start is ignored while busy, stop aborts from any active state.
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   start        begin a sequence from IDLE or DONE (ignored in RUN/PAUSE)
//   stop         abort to IDLE from RUN, PAUSE or DONE; wins over everything else
//   pause        (only with COUNTER_CTRL_PAUSE_EN) freeze the count while in RUN
//   period       terminal value P, latched when a start is accepted
//   auto_reload  at the terminal edge: 1 restarts from 0, 0 stops in DONE
//   count        current count, never exceeds the latched period
//   busy         high in RUN or PAUSE
//   tc           one-cycle pulse after the terminal edge
//   done         high while in DONE
//
// Optional feature macro: COUNTER_CTRL_PAUSE_EN adds the pause port and PAUSE state.

module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef COUNTER_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] period,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

`ifdef COUNTER_CTRL_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] period_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            period_q <= '0;
            busy     <= 1'b0;
            tc       <= 1'b0;
            done     <= 1'b0;
        end else begin
            // tc is a single-cycle pulse; only the terminal branch raises it
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        period_q <= period;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (stop) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == period_q) begin
                        // terminal count beats pause; auto_reload only matters here
                        tc <= 1'b1;
                        if (auto_reload) begin
                            count <= '0;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
`ifdef COUNTER_CTRL_PAUSE_EN
                    end else if (pause) begin
                        state <= PAUSE;
`endif
                    end else begin
                        count <= count + ONE;
                    end
                end

`ifdef COUNTER_CTRL_PAUSE_EN
                PAUSE: begin
                    if (stop) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!pause) begin
                        // PAUSE is only entered below the terminal value, so the
                        // resume edge counts on; the sequence slips exactly by the
                        // number of cycles pause was high
                        count <= count + ONE;
                        state <= RUN;
                    end
                end
`endif

                DONE: begin
                    if (stop) begin
                        count <= '0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end else if (start) begin
                        period_q <= period;
                        count    <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= RUN;
                    end
                end

                default: begin
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios followed by random stimulus,
// every cycle compared with a sequence-level reference model.

module tb_counter_ctrl;

    localparam int W = 4;
`ifdef COUNTER_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] period;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
`ifdef COUNTER_CTRL_PAUSE_EN
        .pause       (pause),
`endif
        .period      (period),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_tc     = 0;

    // Reference model: a sequence is "active" (counting or frozen) or
    // "finished" (holding P); neither means idle.
    bit m_active, m_finished, m_frozen, m_tc;
    int m_cnt, m_per;

    task automatic model_reset();
        m_active = 0; m_finished = 0; m_frozen = 0; m_tc = 0;
        m_cnt = 0; m_per = 0;
    endtask

    task automatic model_edge(input bit s, input bit sp, input bit ar, input bit ps, input int p);
        m_tc = 0;
        if (!m_active && !m_finished) begin
            if (s) begin m_per = p; m_cnt = 0; m_active = 1; end
        end else if (sp) begin
            m_active = 0; m_finished = 0; m_frozen = 0; m_cnt = 0;
        end else if (m_finished) begin
            if (s) begin m_per = p; m_cnt = 0; m_active = 1; m_finished = 0; end
        end else if (m_frozen) begin
            if (!ps) begin m_frozen = 0; m_cnt = m_cnt + 1; end
        end else if (m_cnt == m_per) begin
            m_tc = 1;
            if (ar) m_cnt = 0;
            else begin m_active = 0; m_finished = 1; end
        end else if (ps) begin
            m_frozen = 1;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit s, input bit sp, input int p, input bit ar, input bit ps);
        start = s; stop = sp; period = W'(p); auto_reload = ar; pause = ps;
    endtask

    // One rising edge; model follows the same sampled inputs; outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(start, stop, auto_reload, PAUSE_EN ? pause : 1'b0, int'(period));
        @(negedge clk);
        chk("count", 32'(count), 32'(m_cnt));
        chk("busy",  32'(busy),  32'(m_active));
        chk("tc",    32'(tc),    32'(m_tc));
        chk("done",  32'(done),  32'(m_finished));
        if (tc === 1'b1) n_tc++;
    endtask

    initial begin
        int tc0;
        int steps;

        // reset state
        model_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        #20;
        chk("rst_count", 32'(count), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_tc",    32'(tc),    0);
        chk("rst_done",  32'(done),  0);
        rst = 1'b1;

        // single-shot, period 5
        drive(1, 0, 5, 0, 0);
        step();
        drive(0, 0, 5, 0, 0);
        tc0 = n_tc;
        for (int i = 0; i < 9; i++) step();
        chk("oneshot_count", 32'(count), 5);
        chk("oneshot_done",  32'(done),  1);
        chk("oneshot_busy",  32'(busy),  0);
        chk("oneshot_ntc",   32'(n_tc - tc0), 1);

        // auto-reload, period 3: tc every 4 cycles, busy stays high
        drive(0, 1, 0, 0, 0); step();
        drive(1, 0, 3, 1, 0); step();
        drive(0, 0, 9, 1, 0);
        tc0 = n_tc;
        for (int i = 0; i < 12; i++) step();
        chk("reload3_ntc",  32'(n_tc - tc0), 3);
        chk("reload3_busy", 32'(busy), 1);

        // full-range period with reload
        drive(0, 1, 0, 0, 0); step();
        drive(1, 0, 15, 1, 0); step();
        drive(0, 0, 2, 1, 0);
        tc0 = n_tc;
        for (int i = 0; i < 34; i++) step();
        chk("reload15_ntc", 32'(n_tc - tc0), 2);

        // stop together with start at the terminal value
        drive(0, 1, 0, 0, 0); step();
        drive(1, 0, 4, 0, 0); step();
        drive(0, 0, 4, 0, 0);
        for (int i = 0; i < 20 && m_cnt != 4; i++) step();
        drive(1, 1, 4, 0, 0); step();
        chk("stopterm_count", 32'(count), 0);
        chk("stopterm_tc",    32'(tc),    0);
        chk("stopterm_done",  32'(done),  0);
        chk("stopterm_busy",  32'(busy),  0);

        // asynchronous reset mid-sequence
        drive(0, 0, 0, 0, 0); step();
        drive(1, 0, 7, 0, 0); step();
        drive(0, 0, 7, 0, 0);
        for (int i = 0; i < 20 && m_cnt != 2; i++) step();
        chk("arst_pre_count", 32'(count), 2);
        tc0 = n_tc;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_count", 32'(count), 0);
        chk("arst_busy",  32'(busy),  0);
        chk("arst_tc",    32'(tc),    0);
        chk("arst_done",  32'(done),  0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        chk("arst_ntc", 32'(n_tc - tc0), 0);

        if (PAUSE_EN) begin
            // pause 3 cycles at count 2 of period 6: tc 3 cycles later than nominal
            drive(0, 1, 0, 0, 0); step();
            drive(1, 0, 6, 0, 0); step();
            steps = 1;
            drive(0, 0, 6, 0, 0);
            for (int i = 0; i < 20 && m_cnt != 2; i++) begin step(); steps++; end
            drive(0, 0, 6, 0, 1);
            for (int i = 0; i < 3; i++) begin
                step(); steps++;
                chk("pause_count", 32'(count), 2);
                chk("pause_busy",  32'(busy),  1);
            end
            drive(0, 0, 6, 0, 0);
            for (int i = 0; i < 30 && tc !== 1'b1; i++) begin step(); steps++; end
            chk("pause_tc_steps", 32'(steps), 11);
        end

        // random traffic
        drive(0, 1, 0, 0, 0); step();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, observed %0d checks", n_checks);
        $fatal(1);
    end

endmodule
